// File: rtl/pipe_mul_arbiter.sv
// Round-robin front end that shares one pipelined integer multiplier among
// NREQ requesters. An in-order tag FIFO records who issued each operation so
// that every commit is routed back to its issuer. The in-flight count is capped
// at DEPTH because the multiplier cannot be back-pressured.
module pipe_mul_arbiter #(
   parameter int NREQ  = 4,
   parameter int DEPTH = 8,
   parameter int IDW   = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NREQ-1:0]             req_val,
   input  logic [32*NREQ-1:0]          req_a,
   input  logic [32*NREQ-1:0]          req_b,
   output logic [NREQ-1:0]             req_rdy,
   output logic [NREQ-1:0]             resp_val,
   output logic [63:0]                 resp_p,
   output logic [31:0]                 mul_intA,
   output logic [31:0]                 mul_intB,
   output logic                        mul_val_op,
   input  logic                        mul_oprand_rdy,
   input  logic                        mul_commit,
   input  logic [63:0]                 mul_longP,
   output logic [$clog2(DEPTH):0]      inflight,
   output logic                        err_orphan
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   inflight_q, inflight_d;
   logic [IDW-1:0]  tag_q [DEPTH];
   logic [IDW-1:0]  tag_d [DEPTH];
   logic [NREQ-1:0] resp_val_q, resp_val_d;
   logic [63:0]     resp_p_q, resp_p_d;
   logic            err_orphan_q, err_orphan_d;

   logic            fifo_empty, can_issue, push, pop;
   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  gnt_id, head_id;

   assign fifo_empty = (inflight_q == '0);
   // A same-cycle commit frees a slot, so a full FIFO may still issue.
   assign can_issue  = mul_oprand_rdy & ((inflight_q < CW'(DEPTH)) | mul_commit);
   assign head_id    = tag_q[rd_ptr_q];
   assign push       = |grant;
   assign pop        = mul_commit & ~fifo_empty;

   // Round-robin search starting at rr_ptr; gnt_id defaults to rr_ptr so the
   // operand mux has a defined source when nothing is granted.
   always_comb begin
      logic found;
      int   idx;
      grant  = '0;
      gnt_id = rr_ptr_q;
      found  = 1'b0;
      idx    = 0;
      if (can_issue) begin
         for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_val[idx]) begin
               found      = 1'b1;
               grant[idx] = 1'b1;
               gnt_id     = IDW'(idx);
            end
         end
      end
   end

   // Zero-latency issue datapath to the multiplier.
   always_comb begin
      req_rdy    = grant;
      mul_val_op = push;
      mul_intA   = req_a[32*int'(gnt_id) +: 32];
      mul_intB   = req_b[32*int'(gnt_id) +: 32];
   end

   // Next-state: pointer advance, tag FIFO, in-flight count, response capture.
   always_comb begin
      rr_ptr_d     = rr_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      inflight_d   = inflight_q;
      tag_d        = tag_q;
      resp_val_d   = '0;
      resp_p_d     = resp_p_q;
      err_orphan_d = err_orphan_q | (mul_commit & fifo_empty);
      if (push) begin
         tag_d[wr_ptr_q] = gnt_id;
         wr_ptr_d        = wr_ptr_q + PW'(1);
         rr_ptr_d        = (int'(gnt_id) == NREQ-1) ? '0 : gnt_id + IDW'(1);
      end
      if (pop) begin
         rd_ptr_d            = rd_ptr_q + PW'(1);
         resp_val_d[head_id] = 1'b1;
         resp_p_d            = mul_longP;
      end
      if (push && !pop)      inflight_d = inflight_q + CW'(1);
      else if (pop && !push) inflight_d = inflight_q - CW'(1);
   end

   // State registers; reset discards all in-flight tags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         inflight_q   <= '0;
         tag_q        <= '{default: '0};
         resp_val_q   <= '0;
         resp_p_q     <= '0;
         err_orphan_q <= 1'b0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         inflight_q   <= inflight_d;
         tag_q        <= tag_d;
         resp_val_q   <= resp_val_d;
         resp_p_q     <= resp_p_d;
         err_orphan_q <= err_orphan_d;
      end
   end

   assign resp_val   = resp_val_q;
   assign resp_p     = resp_p_q;
   assign inflight   = inflight_q;
   assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_pipe_mul_arbiter.sv
// Directed bench for pipe_mul_arbiter. The bench plays the multiplier itself:
// it drives mul_oprand_rdy, mul_commit and mul_longP with hand-computed products.
module tb_pipe_mul_arbiter;

   logic         clk = 1'b0;
   logic         reset;
   logic [3:0]   req_val;
   logic [127:0] req_a, req_b;
   logic [3:0]   req_rdy, resp_val;
   logic [63:0]  resp_p;
   logic [31:0]  mul_intA, mul_intB;
   logic         mul_val_op;
   logic         mul_oprand_rdy, mul_commit;
   logic [63:0]  mul_longP;
   logic [3:0]   inflight;
   logic         err_orphan;

   int errors = 0;
   int checks = 0;

   pipe_mul_arbiter #(.NREQ(4), .DEPTH(8), .IDW(2)) dut (
      .clk(clk), .reset(reset), .req_val(req_val), .req_a(req_a), .req_b(req_b),
      .req_rdy(req_rdy), .resp_val(resp_val), .resp_p(resp_p),
      .mul_intA(mul_intA), .mul_intB(mul_intB), .mul_val_op(mul_val_op),
      .mul_oprand_rdy(mul_oprand_rdy), .mul_commit(mul_commit),
      .mul_longP(mul_longP), .inflight(inflight), .err_orphan(err_orphan)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled at the falling edge.
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0; req_val = '0; mul_commit = 1'b0; mul_longP = '0;
      mul_oprand_rdy = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0; req_val = '0; req_a = '0; req_b = '0;
      mul_oprand_rdy = 1'b1; mul_commit = 1'b0; mul_longP = '0;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL reset_inflight got %0d want 0", inflight); end
      checks++; if (resp_val !== 4'b0) begin errors++; $display("FAIL reset_resp_val got %b want 0000", resp_val); end
      checks++; if (resp_p !== 64'd0) begin errors++; $display("FAIL reset_resp_p got %0h want 0", resp_p); end
      checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_orphan); end
      checks++; if (req_rdy !== 4'b0 || mul_val_op !== 1'b0) begin errors++; $display("FAIL reset_grant got %b/%b want 0000/0", req_rdy, mul_val_op); end
      reset = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      @(negedge clk);
      req_a[64 +: 32] = 32'd7; req_b[64 +: 32] = 32'd6; req_val = 4'b0100;
      #1;
      checks++; if (req_rdy !== 4'b0100) begin errors++; $display("FAIL single_rdy got %b want 0100", req_rdy); end
      checks++; if (mul_val_op !== 1'b1 || mul_intA !== 32'd7 || mul_intB !== 32'd6) begin
         errors++; $display("FAIL single_issue got %b %0d %0d want 1 7 6", mul_val_op, mul_intA, mul_intB); end
      @(negedge clk);
      req_val = '0;
      checks++; if (inflight !== 4'd1) begin errors++; $display("FAIL single_inflight got %0d want 1", inflight); end
      checks++; if (resp_val !== 4'b0) begin errors++; $display("FAIL single_early_resp got %b want 0000", resp_val); end
      mul_commit = 1'b1; mul_longP = 64'd42;
      @(negedge clk);
      mul_commit = 1'b0; mul_longP = '0;
      checks++; if (resp_val !== 4'b0100 || resp_p !== 64'd42) begin
         errors++; $display("FAIL single_resp got %b %0d want 0100 42", resp_val, resp_p); end
      checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL single_drain got %0d want 0", inflight); end
      @(negedge clk);
      checks++; if (resp_val !== 4'b0 || resp_p !== 64'd42) begin
         errors++; $display("FAIL single_strobe got %b %0d want 0000 42", resp_val, resp_p); end
   endtask

   // Eight grants with all requesters valid must go 0,1,2,3,0,1,2,3; then
   // eight back-to-back commits return (i+1)*100 to requester i in that order.
   task automatic test_fairness();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         req_a[32*i +: 32] = 32'(i + 1); req_b[32*i +: 32] = 32'd100;
      end
      @(negedge clk);
      req_val = 4'b1111;
      for (int c = 0; c < 8; c++) begin
         #1;
         checks++; if (req_rdy !== 4'(1 << (c % 4)) || mul_intA !== 32'((c % 4) + 1)) begin
            errors++; $display("FAIL fair_grant%0d got %b a=%0d want %b a=%0d", c, req_rdy, mul_intA, 4'(1 << (c % 4)), (c % 4) + 1); end
         @(negedge clk);
      end
      req_val = '0;
      checks++; if (inflight !== 4'd8) begin errors++; $display("FAIL fair_inflight got %0d want 8", inflight); end
      for (int c = 0; c < 8; c++) begin
         mul_commit = 1'b1; mul_longP = 64'(((c % 4) + 1) * 100);
         @(negedge clk);
         checks++; if (resp_val !== 4'(1 << (c % 4)) || resp_p !== 64'(((c % 4) + 1) * 100)) begin
            errors++; $display("FAIL fair_resp%0d got %b %0d want %b %0d", c, resp_val, resp_p, 4'(1 << (c % 4)), ((c % 4) + 1) * 100); end
      end
      mul_commit = 1'b0;
      @(negedge clk);
      checks++; if (inflight !== 4'd0 || resp_val !== 4'b0) begin errors++; $display("FAIL fair_drain got %0d %b want 0 0000", inflight, resp_val); end
   endtask

   task automatic test_credit();
      int grants;
      grants = 0;
      do_reset();
      @(negedge clk);
      req_val = 4'b1111;
      for (int c = 0; c < 11; c++) begin
         #1;
         if (req_rdy !== 4'b0) grants++;
         @(negedge clk);
      end
      checks++; if (grants !== 8) begin errors++; $display("FAIL credit_grants got %0d want 8", grants); end
      checks++; if (req_rdy !== 4'b0 || inflight !== 4'd8) begin
         errors++; $display("FAIL credit_full got %b %0d want 0000 8", req_rdy, inflight); end
      mul_commit = 1'b1; mul_longP = 64'd100;
      #1;
      checks++; if (req_rdy !== 4'b0001) begin errors++; $display("FAIL credit_reissue got %b want 0001", req_rdy); end
      @(negedge clk);
      mul_commit = 1'b0; req_val = '0;
      checks++; if (inflight !== 4'd8 || resp_val !== 4'b0001) begin
         errors++; $display("FAIL credit_swap got %0d %b want 8 0001", inflight, resp_val); end
      mul_commit = 1'b1;
      repeat (8) @(negedge clk);
      mul_commit = 1'b0;
      checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL credit_drain got %0d want 0", inflight); end
   endtask

   task automatic test_stall();
      int stray;
      stray = 0;
      do_reset();
      @(negedge clk);
      req_val = 4'b1010; mul_oprand_rdy = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         if (req_rdy !== 4'b0 || mul_val_op !== 1'b0) stray++;
         @(negedge clk);
      end
      checks++; if (stray !== 0) begin errors++; $display("FAIL stall_nogrant got %0d want 0", stray); end
      checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL stall_inflight got %0d want 0", inflight); end
      mul_oprand_rdy = 1'b1;
      #1;
      checks++; if (req_rdy !== 4'b0010) begin errors++; $display("FAIL stall_first got %b want 0010", req_rdy); end
      @(negedge clk);
      #1;
      checks++; if (req_rdy !== 4'b1000) begin errors++; $display("FAIL stall_second got %b want 1000", req_rdy); end
      @(negedge clk);
      req_val = '0;
      checks++; if (inflight !== 4'd2) begin errors++; $display("FAIL stall_count got %0d want 2", inflight); end
      mul_commit = 1'b1; mul_longP = 64'd11;
      @(negedge clk);
      mul_longP = 64'd33;
      checks++; if (resp_val !== 4'b0010 || resp_p !== 64'd11) begin errors++; $display("FAIL stall_resp1 got %b %0d want 0010 11", resp_val, resp_p); end
      @(negedge clk);
      mul_commit = 1'b0;
      checks++; if (resp_val !== 4'b1000 || resp_p !== 64'd33) begin errors++; $display("FAIL stall_resp3 got %b %0d want 1000 33", resp_val, resp_p); end
   endtask

   task automatic test_orphan();
      do_reset();
      @(negedge clk);
      mul_commit = 1'b1; mul_longP = 64'd99;
      @(negedge clk);
      mul_commit = 1'b0;
      checks++; if (resp_val !== 4'b0 || inflight !== 4'd0 || resp_p !== 64'd0) begin
         errors++; $display("FAIL orphan_noresp got %b %0d %0d want 0000 0 0", resp_val, inflight, resp_p); end
      checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_flag got %b want 1", err_orphan); end
      repeat (3) @(negedge clk);
      checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_sticky got %b want 1", err_orphan); end
      do_reset();
      checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL orphan_clear got %b want 0", err_orphan); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      @(negedge clk);
      mul_commit = 1'b1; mul_longP = 64'd123;   // orphan sets err and nothing else
      @(negedge clk);
      mul_commit = 1'b0; req_val = 4'b0111;
      repeat (3) @(negedge clk);
      req_val = '0;
      checks++; if (inflight !== 4'd3 || err_orphan !== 1'b1) begin errors++; $display("FAIL mid_pre got %0d %b want 3 1", inflight, err_orphan); end
      #2 reset = 1'b0;
      #1;
      checks++; if (inflight !== 4'd0 || resp_val !== 4'b0 || resp_p !== 64'd0 || err_orphan !== 1'b0) begin
         errors++; $display("FAIL mid_async got %0d %b %0h %b want 0 0000 0 0", inflight, resp_val, resp_p, err_orphan); end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      req_a[32 +: 32] = 32'hFFFF_FFFF; req_b[32 +: 32] = 32'd2; req_val = 4'b0010;
      #1;
      checks++; if (req_rdy !== 4'b0010 || mul_intA !== 32'hFFFF_FFFF || mul_intB !== 32'd2) begin
         errors++; $display("FAIL mid_issue got %b %0h %0h want 0010 ffffffff 2", req_rdy, mul_intA, mul_intB); end
      @(negedge clk);
      req_val = '0; mul_commit = 1'b1; mul_longP = 64'h1_FFFF_FFFE;
      @(negedge clk);
      mul_commit = 1'b0;
      checks++; if (resp_val !== 4'b0010 || resp_p !== 64'h1_FFFF_FFFE) begin
         errors++; $display("FAIL mid_resp got %b %0h want 0010 1fffffffe", resp_val, resp_p); end
      checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL mid_drain got %0d want 0", inflight); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_credit();
      test_stall();
      test_orphan();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_mul_arbiter.md
Name: pipe_mul_arbiter

Overview:
- Shares one PipeIntMul instance among NREQ requesters using round-robin issue arbitration.
- Records the requester ID of every issued operation in an in-order tag FIFO, then routes each multiplier commit back to the requester that issued it.
- Caps in-flight operations at DEPTH, because PipeIntMul results cannot be back-pressured.
- Sits between requester engines and the multiplier; the multiplier's reset is driven from the same reset net.

Parameters:
- NREQ, 4: number of requesters, 2..8.
- DEPTH, 8: maximum in-flight operations and tag FIFO depth; power of 2, must be at least the multiplier pipeline depth.
- IDW, 2: requester ID width, clog2(NREQ).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_val  in  NREQ  per-requester operation valid.
- req_a  in  32*NREQ  operand A; requester i uses bits [32i+31:32i].
- req_b  in  32*NREQ  operand B, same packing as req_a.
- req_rdy  out  NREQ  one-hot grant; the operation transfers when req_val[i]&req_rdy[i].
- resp_val  out  NREQ  one-hot, one-cycle response strobe.
- resp_p  out  64  product for the current response.
- mul_intA  out  32  to multiplier intA.
- mul_intB  out  32  to multiplier intB.
- mul_val_op  out  1  to multiplier val_op.
- mul_oprand_rdy  in  1  from multiplier; high means the operand is accepted this cycle.
- mul_commit  in  1  from multiplier; result valid.
- mul_longP  in  64  from multiplier product.
- inflight  out  clog2(DEPTH)+1  count of operations issued but not yet committed.
- err_orphan  out  1  sticky flag: a commit arrived with the tag FIFO empty.

Behaviour:
- Reset (reset=0, asynchronous):
  - rr_ptr=0, FIFO empty, inflight=0, resp_val=0, resp_p=0, err_orphan=0.
  - All in-flight tags are discarded; the multiplier is reset simultaneously, so no stale commits arrive.
- Issue enable (combinational): can_issue = mul_oprand_rdy & (inflight<DEPTH | mul_commit). A same-cycle pop frees a slot, so issue is allowed when full if a commit is also present.
- Grant (combinational):
  - When can_issue, grant goes to the first i with req_val[i]=1, searching rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_rdy=grant. At most one bit is set; all bits are 0 when can_issue=0 or no request is valid.
- Datapath:
  - mul_val_op = |grant.
  - mul_intA/mul_intB = operands of the granted requester, else operands of requester rr_ptr. Operands are don't-care when mul_val_op=0.
  - The datapath is combinational and adds zero issue latency.
- On a grant to i (clock edge):
  - push i into the tag FIFO;
  - rr_ptr <= (i+1) mod NREQ.
  - rr_ptr holds when there is no grant.
- Commit:
  - On mul_commit=1 with the FIFO non-empty: pop the head tag t.
  - Next cycle: resp_val = 1<<t, resp_p = mul_longP.
  - Response latency is exactly 1 cycle after commit.
  - Requesters must accept responses unconditionally.
- resp_val is 0 in every cycle not following a valid commit. resp_p holds its last value.
- inflight: +1 on push only, -1 on pop only, unchanged on push+pop or neither.
- Orphan commit (mul_commit=1 with the FIFO empty): no pop, no response, err_orphan <= 1 until reset.
- Ordering: responses for a given requester return in issue order. Global response order equals global issue order.
- FIFO pointers wrap mod DEPTH. inflight never exceeds DEPTH and never underflows.

Test Plan:
- Single request: requester 2 sends a=7, b=6 once → req_rdy=0100 in the issue cycle, mul_val_op=1, resp_val=0100 with resp_p=42 one cycle after mul_commit; inflight returns 0.
- Fairness: all 4 requesters hold req_val=1 with oprand_rdy=1 → grants follow the sequence 0,1,2,3,0,1,... Every product routes to its issuer; requester i uses a=i+1, b=100, so products are 100/200/300/400.
- Credit limit: stub multiplier holds commit low → exactly DEPTH=8 grants, then req_rdy=0 and inflight=8. A single commit with all requests still asserted → grant in the same cycle, inflight stays 8.
- Multiplier stall: mul_oprand_rdy=0 for 5 cycles while requesters 1 and 3 are valid → no grant, rr_ptr unchanged. When rdy returns → requester 1 is granted first, then 3.
- Orphan: mul_commit pulsed with inflight=0 → resp_val stays 0 and err_orphan=1 until reset.
- Reset mid-operation: 3 in flight, assert reset low for 2 cycles → all outputs return to reset values; a subsequent single request a=0xFFFFFFFF, b=2 → resp_p=0x1FFFFFFFE to the correct requester.
